// File: rtl/demux14_frame_rx.sv
// demux14_frame_rx
// Receive side of a 4:1 time-multiplexed lane link. Each cycle, one word tagged
// with a 2-bit lane select is steered into one of four registered lane holders.
// A 4-lane frame snapshot is published once every lane has been written.
//
// Ports:
//   i_CLK          system clock, rising edge
//   i_RST          synchronous active-high reset
//   i_DATA         incoming lane word (WIDTH bits)
//   i_SEL0/i_SEL1  lane select, lane = {i_SEL1,i_SEL0}: 0=A 1=B 2=C 3=D
//   i_VALID        word present this cycle
//   i_CLR_ERR      clears sticky o_DUP_ERR (a same-edge duplicate wins)
//   o_A..o_D       last word written to each lane
//   o_STB          one-hot strobe of the lane updated on the previous edge
//   o_FRAME        {D,C,B,A} snapshot of the last completed frame
//   o_FRAME_VALID  one-cycle pulse when o_FRAME is updated
//   o_DUP_ERR      sticky: a lane was rewritten before its frame completed
module demux14_frame_rx #(
    parameter int WIDTH = 1
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic [WIDTH-1:0]   i_DATA,
    input  logic               i_SEL0,
    input  logic               i_SEL1,
    input  logic               i_VALID,
    input  logic               i_CLR_ERR,
    output logic [WIDTH-1:0]   o_A,
    output logic [WIDTH-1:0]   o_B,
    output logic [WIDTH-1:0]   o_C,
    output logic [WIDTH-1:0]   o_D,
    output logic [3:0]         o_STB,
    output logic [4*WIDTH-1:0] o_FRAME,
    output logic               o_FRAME_VALID,
    output logic               o_DUP_ERR
);

    logic [1:0]       lane_p0;
    logic [3:0]       lane_oh_p0;
    logic [3:0]       mask_p1;
    logic [3:0]       mask_merged_p0;
    logic             dup_p0;
    logic             complete_p0;
    logic [WIDTH-1:0] a_nxt_p0;
    logic [WIDTH-1:0] b_nxt_p0;
    logic [WIDTH-1:0] c_nxt_p0;
    logic [WIDTH-1:0] d_nxt_p0;

    // Stage p0: decode the incoming word against the written-mask
    always_comb begin
        lane_p0        = {i_SEL1, i_SEL0};
        lane_oh_p0     = 4'b0001 << lane_p0;
        mask_merged_p0 = mask_p1 | lane_oh_p0;
        dup_p0         = i_VALID && ((mask_p1 & lane_oh_p0) != 4'b0000);
        complete_p0    = i_VALID && (mask_merged_p0 == 4'b1111);
        // Frame snapshot must use the word arriving on the completing edge,
        // not the stale lane register.
        a_nxt_p0 = (i_VALID && lane_p0 == 2'd0) ? i_DATA : o_A;
        b_nxt_p0 = (i_VALID && lane_p0 == 2'd1) ? i_DATA : o_B;
        c_nxt_p0 = (i_VALID && lane_p0 == 2'd2) ? i_DATA : o_C;
        d_nxt_p0 = (i_VALID && lane_p0 == 2'd3) ? i_DATA : o_D;
    end

    // Stage p1: registered lanes, strobe, mask, frame and error flag
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_A           <= '0;
            o_B           <= '0;
            o_C           <= '0;
            o_D           <= '0;
            o_STB         <= 4'b0000;
            o_FRAME       <= '0;
            o_FRAME_VALID <= 1'b0;
            o_DUP_ERR     <= 1'b0;
            mask_p1       <= 4'b0000;
        end else begin
            o_STB         <= i_VALID ? lane_oh_p0 : 4'b0000;
            o_FRAME_VALID <= complete_p0;
            if (i_VALID) begin
                o_A <= a_nxt_p0;
                o_B <= b_nxt_p0;
                o_C <= c_nxt_p0;
                o_D <= d_nxt_p0;
                // The completing word starts no new frame; a duplicate
                // leaves the mask as is since its bit is already set.
                if (complete_p0) begin
                    o_FRAME <= {d_nxt_p0, c_nxt_p0, b_nxt_p0, a_nxt_p0};
                    mask_p1 <= 4'b0000;
                end else begin
                    mask_p1 <= mask_merged_p0;
                end
            end
            if (dup_p0)
                o_DUP_ERR <= 1'b1;
            else if (i_CLR_ERR)
                o_DUP_ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux14_frame_rx.sv
module tb_demux14_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = '0;
    logic        sel0 = 1'b0;
    logic        sel1 = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;

    logic [7:0]  a8, b8, c8, d8;
    logic [3:0]  stb8;
    logic [31:0] frame8;
    logic        fv8, dup8;

    logic        a1, b1, c1, d1;
    logic [3:0]  stb1;
    logic [3:0]  frame1;
    logic        fv1, dup1;

    always #5 clk = ~clk;

    demux14_frame_rx #(.WIDTH(8)) dut8 (
        .i_CLK(clk), .i_RST(rst), .i_DATA(data), .i_SEL0(sel0), .i_SEL1(sel1),
        .i_VALID(valid), .i_CLR_ERR(clr),
        .o_A(a8), .o_B(b8), .o_C(c8), .o_D(d8), .o_STB(stb8),
        .o_FRAME(frame8), .o_FRAME_VALID(fv8), .o_DUP_ERR(dup8)
    );

    demux14_frame_rx #(.WIDTH(1)) dut1 (
        .i_CLK(clk), .i_RST(rst), .i_DATA(data[0]), .i_SEL0(sel0), .i_SEL1(sel1),
        .i_VALID(valid), .i_CLR_ERR(clr),
        .o_A(a1), .o_B(b1), .o_C(c1), .o_D(d1), .o_STB(stb1),
        .o_FRAME(frame1), .o_FRAME_VALID(fv1), .o_DUP_ERR(dup1)
    );

    typedef struct {
        logic [7:0]  lane [4];
        logic [3:0]  stb;
        logic [31:0] frame;
        logic        fv;
        logic        dup;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0]  m_lane [4];
    logic [3:0]  m_written;
    logic [3:0]  m_stb;
    logic [31:0] m_frame;
    logic        m_fv;
    logic        m_dup;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int fv_count = 0;
    int fv_last  = -100;
    int fv_gap   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    function automatic void model_step(input logic r, input logic v, input int ln,
                                       input logic [7:0] d, input logic c);
        if (r) begin
            for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
            m_written = 4'b0000;
            m_stb = 4'b0000;
            m_frame = 32'h0;
            m_fv = 1'b0;
            m_dup = 1'b0;
        end else begin
            m_fv  = 1'b0;
            m_stb = 4'b0000;
            if (v && m_written[ln]) m_dup = 1'b1;
            else if (c) m_dup = 1'b0;
            if (v) begin
                m_stb[ln] = 1'b1;
                m_lane[ln] = d;
                m_written[ln] = 1'b1;
                if (m_written == 4'b1111) begin
                    m_frame = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
                    m_fv = 1'b1;
                    m_written = 4'b0000;
                end
            end
        end
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue the expectation
    task automatic drive(input logic r, input logic v, input int ln,
                         input logic [7:0] d, input logic c);
        exp_t e;
        @(negedge clk);
        rst   = r;
        valid = v;
        sel0  = ln[0];
        sel1  = ln[1];
        data  = d;
        clr   = c;
        model_step(r, v, ln, d, c);
        for (int i = 0; i < 4; i++) e.lane[i] = m_lane[i];
        e.stb = m_stb;
        e.frame = m_frame;
        e.fv = m_fv;
        e.dup = m_dup;
        exp_q.push_back(e);
    endtask

    task automatic wr(input int ln, input logic [7:0] d);
        drive(1'b0, 1'b1, ln, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom_range(0, 3), 8'($urandom), 1'b0);
    endtask

    // Scoreboard: pop one expectation per edge and compare both instances
    always @(posedge clk) begin
        #1;
        cycle++;
        if (fv8) begin
            fv_gap = cycle - fv_last;
            fv_last = cycle;
            fv_count++;
        end
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("lane_a", {24'h0, a8}, {24'h0, e.lane[0]});
            check("lane_b", {24'h0, b8}, {24'h0, e.lane[1]});
            check("lane_c", {24'h0, c8}, {24'h0, e.lane[2]});
            check("lane_d", {24'h0, d8}, {24'h0, e.lane[3]});
            check("stb", {28'h0, stb8}, {28'h0, e.stb});
            check("frame_valid", {31'h0, fv8}, {31'h0, e.fv});
            check("frame", frame8, e.frame);
            check("dup_err", {31'h0, dup8}, {31'h0, e.dup});
            check("w1_lanes", {28'h0, d1, c1, b1, a1},
                  {28'h0, e.lane[3][0], e.lane[2][0], e.lane[1][0], e.lane[0][0]});
            check("w1_stb", {28'h0, stb1}, {28'h0, e.stb});
            check("w1_frame", {28'h0, frame1},
                  {28'h0, e.frame[24], e.frame[16], e.frame[8], e.frame[0]});
            check("w1_fv_dup", {30'h0, fv1, dup1}, {30'h0, e.fv, e.dup});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        // Scenario 1: reset then in-order frame
        drive(1'b1, 1'b0, 0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 0, 8'h00, 1'b0);
        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33);
        cnt0 = fv_count;
        wr(3, 8'h44);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s1_frame", frame8, 32'h44332211);
        check("s1_pulses", fv_count - cnt0, 1);

        // Scenario 2: out-of-order
        wr(3, 8'hDD); wr(0, 8'hAA); wr(2, 8'hCC); wr(1, 8'hBB);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s2_frame", frame8, 32'hDDCCBBAA);
        check("s2_dup", {31'h0, dup8}, 32'h0);

        // Scenario 3: duplicate A, then clear
        wr(0, 8'h01); wr(0, 8'h02); wr(1, 8'h03); wr(2, 8'h04); wr(3, 8'h05);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s3_frame", frame8, 32'h05040302);
        check("s3_dup_set", {31'h0, dup8}, 32'h1);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s3_dup_clr", {31'h0, dup8}, 32'h0);

        // Scenario 4: random gaps, then two back-to-back frames
        wr(2, 8'h5A); idle($urandom_range(1, 3));
        wr(0, 8'hA5); idle($urandom_range(1, 3));
        wr(3, 8'h3C); idle($urandom_range(1, 3));
        wr(1, 8'hC3); idle(2);
        for (int f = 0; f < 2; f++)
            for (int l = 0; l < 4; l++) wr(l, 8'(8'h60 + f * 4 + l));
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s4_gap", fv_gap, 4);
        check("s4_frame", frame8, 32'h67666564);

        // Scenario 5: reset mid-frame discards partial frame
        wr(0, 8'h71); wr(1, 8'h72);
        drive(1'b1, 1'b1, 2, 8'h73, 1'b0);
        cnt0 = fv_count;
        wr(2, 8'h74); wr(3, 8'h75);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s5_no_frame", fv_count - cnt0, 0);
        wr(0, 8'h76); wr(1, 8'h77);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s5_frame", frame8, 32'h75747776);

        // Scenario 6: duplicate and clear on the same edge -> set wins
        wr(0, 8'h10);
        drive(1'b0, 1'b1, 0, 8'h20, 1'b1);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s6_set_wins", {31'h0, dup8}, 32'h1);

        // WIDTH=1 pattern 1,0,1,1 after reset
        drive(1'b1, 1'b0, 0, 8'h00, 1'b0);
        wr(0, 8'h01); wr(1, 8'h00); wr(2, 8'h01); wr(3, 8'h01);
        drive(1'b0, 1'b0, 0, 8'h00, 1'b0);
        @(posedge clk); #2;
        check("s6_w1_frame", {28'h0, frame1}, 32'hD);
        check("s6_w8_frame", frame8, 32'h01010001);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux14_frame_rx.md
Name: demux14_frame_rx

Overview:
Receive-side counterpart of the 4:1 lane mux. It takes one data word per cycle, tagged with a 2-bit lane select, and steers it into one of four registered lane holders. It also assembles a complete 4-lane frame once every lane has been written. It sits at the far end of a time-multiplexed link and rebuilds the four original signals that the mux serialised onto one wire.

Parameters:
WIDTH, 1, bit width of each lane word (i_DATA, o_A..o_D); legal range 1..32.

Ports:
i_CLK  in  1  system clock; all state updates on rising edge
i_RST  in  1  synchronous, active-high reset
i_DATA  in  WIDTH  incoming lane word
i_SEL0  in  1  lane select LSB
i_SEL1  in  1  lane select MSB; lane = {i_SEL1,i_SEL0}: 0=A, 1=B, 2=C, 3=D
i_VALID  in  1  word present this cycle; select and data ignored when 0
i_CLR_ERR  in  1  clears sticky o_DUP_ERR
o_A  out  WIDTH  last word written to lane 0
o_B  out  WIDTH  last word written to lane 1
o_C  out  WIDTH  last word written to lane 2
o_D  out  WIDTH  last word written to lane 3
o_STB  out  4  one-hot write strobe, bit n = lane n updated on the previous edge
o_FRAME  out  4*WIDTH  frame snapshot {D,C,B,A}, stable between frame completions
o_FRAME_VALID  out  1  one-cycle pulse: o_FRAME updated with a completed frame
o_DUP_ERR  out  1  sticky: a lane was rewritten before its frame completed

Behaviour:
- Reset (i_RST=1 at an edge):
  - o_A..o_D=0, o_STB=0, o_FRAME=0, o_FRAME_VALID=0, o_DUP_ERR=0.
  - Internal written-mask m[3:0]=0.
  - Reset overrides any i_VALID in the same cycle, including mid-frame; the partial frame is discarded.
- Accept: on an edge with i_VALID=1 and lane L:
  - lane register L <= i_DATA;
  - o_STB <= onehot(L);
  - m[L] set.
- Latency: lane output and strobe are visible 1 cycle after the accepting edge. o_STB is all-zero in any cycle following an edge with i_VALID=0.
- Idle: i_VALID=0 leaves lane registers, m, and o_FRAME unchanged.
- Duplicate write: i_VALID=1 to a lane L whose m[L] is already 1:
  - data is overwritten (the newest word wins);
  - o_DUP_ERR <= 1;
  - m is unchanged.
- Frame completion: on an accepting edge where (m | onehot(L)) == 4'b1111:
  - o_FRAME <= {D,C,B,A}, using the new i_DATA for lane L;
  - o_FRAME_VALID <= 1 for exactly one cycle;
  - m <= 0 on the same edge, so the completing word does not count toward the next frame.
- Lane arrival order is free; any permutation of the 4 lanes completes a frame.
- Back-to-back frames: 4 consecutive accepting cycles produce o_FRAME_VALID pulses every 4 cycles with no dead cycle.
- o_DUP_ERR clear: i_CLR_ERR=1 clears it. If a duplicate write and i_CLR_ERR occur on the same edge, set wins (o_DUP_ERR=1).
- Completion and duplicate cannot coincide: a completing write targets a lane with m[L]=0.
- Purely synchronous, single clock domain; no combinational path from inputs to outputs.

Test Plan:
1. Reset, WIDTH=8: assert i_RST 2 cycles -> all outputs 0. Write A=0x11, B=0x22, C=0x33, D=0x44 on consecutive cycles -> o_STB=0001,0010,0100,1000 on successive cycles; o_FRAME_VALID high exactly once, 1 cycle after the D write; o_FRAME=0x44332211.
2. Out-of-order writes D=0xDD, A=0xAA, C=0xCC, B=0xBB -> one o_FRAME_VALID pulse after the B write; o_FRAME=0xDDCCBBAA; o_DUP_ERR=0.
3. Write A=0x01, then A=0x02, then B/C/D=0x03/0x04/0x05 -> o_DUP_ERR=1 from the cycle after the second A write; o_FRAME=0x05040302. Pulse i_CLR_ERR -> o_DUP_ERR=0 next cycle.
4. Gaps: frame writes separated by random i_VALID=0 cycles -> lane outputs hold, o_STB=0 during gaps, single frame pulse with correct data. Then 8 back-to-back writes (2 frames) -> pulses exactly 4 cycles apart.
5. Mid-frame reset: write A and B, assert i_RST with i_VALID=1 to C -> all outputs 0, C not written. Then write C and D only -> no o_FRAME_VALID; A and B still required.
6. Set/clear collision: duplicate write on the same edge as i_CLR_ERR=1 -> o_DUP_ERR=1. Also run WIDTH=1 with the scenario 1 pattern 1,0,1,1 -> o_FRAME=4'b1101.
